// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared types and constants for the ball subsystem
package ball_pkg;

    // Scheduler sequencing states.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CAL  = 3'd1,
        S_REQ  = 3'd2,
        S_COL  = 3'd3,
        S_NEXT = 3'd4,
        S_DONE = 3'd5
    } sched_state_e;

    // Watchdog cycles allowed per wait before a ball is abandoned.
    localparam int DEFAULT_TIMEOUT = 1023;

    // Widths shared with the ball motion units.
    localparam int DIR_W   = 2;
    localparam int PIXEL_W = 10;

endpackage

// File: rtl/ball_sched_pick.sv
// rtl/ball_sched_pick.sv - next-enabled-ball index finder
module ball_sched_pick
    import ball_pkg::*;
#(
    parameter int N_BALL = 3,
    parameter int IDX_W  = 2
) (
    input  logic [N_BALL-1:0] mask_i,
    input  logic [IDX_W-1:0]  cur_i,
    input  logic              incl_cur_i,
    output logic [IDX_W-1:0]  nxt_o,
    output logic              valid_o
);

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        nxt_o   = '0;
        valid_o = 1'b0;
        for (int i = N_BALL - 1; i >= 0; i--) begin
            if (mask_i[i] && ((i > int'(cur_i)) || (incl_cur_i && (i == int'(cur_i))))) begin
                nxt_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ball_frame_sched.sv
// rtl/ball_frame_sched.sv - per-frame scheduler sharing one collision unit among balls
module ball_frame_sched
    import ball_pkg::*;
#(
    parameter  int N_BALL  = 3,
    parameter  int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int IDX_W   = (N_BALL > 1) ? $clog2(N_BALL) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_frame_tick,
    input  logic              i_game_start,
    input  logic [N_BALL-1:0] i_ball_en,
    output logic              o_cal_frame,
    output logic [N_BALL-1:0] o_ball_req,
    input  logic [N_BALL-1:0] i_ball_ack,
    input  logic [N_BALL-1:0] i_ball_term,
    output logic              o_col_start,
    output logic [IDX_W-1:0]  o_col_idx,
    input  logic              i_col_done,
    output logic              o_frame_done,
    output logic              o_busy,
    output logic              o_overrun,
    output logic              o_timeout
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    sched_state_e      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [N_BALL-1:0] active_q, active_d;
    logic [N_BALL-1:0] done_q, done_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [N_BALL-1:0] req_q, req_d;
    logic              cal_q, cal_d;
    logic              col_start_q, col_start_d;
    logic [IDX_W-1:0]  col_idx_q, col_idx_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;

    logic [N_BALL-1:0] pick_mask;
    logic [IDX_W-1:0]  pick_cur;
    logic              pick_incl;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;

    logic sel_ack;
    logic sel_term;
    logic wd_fire;

    // Only the selected ball's answer counts, and only while it is being asked.
    assign sel_ack  = req_q[idx_q] & i_ball_ack[idx_q];
    assign sel_term = req_q[idx_q] & i_ball_term[idx_q];
    assign wd_fire  = (wd_q == WD_LAST);

    // CAL searches the fresh enable vector from index 0; NEXT searches strictly above idx.
    always_comb begin
        pick_mask = active_q & ~done_q;
        pick_cur  = idx_q;
        pick_incl = 1'b0;
        if (state_q == S_CAL) begin
            pick_mask = i_ball_en;
            pick_cur  = '0;
            pick_incl = 1'b1;
        end
    end

    ball_sched_pick #(
        .N_BALL (N_BALL),
        .IDX_W  (IDX_W)
    ) u_pick (
        .mask_i     (pick_mask),
        .cur_i      (pick_cur),
        .incl_cur_i (pick_incl),
        .nxt_o      (pick_idx),
        .valid_o    (pick_valid)
    );

    // Next-state and registered-output decode; game start overrides everything.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        active_d     = active_q;
        done_d       = done_q;
        wd_d         = wd_q;
        col_idx_d    = col_idx_q;
        cal_d        = 1'b0;
        col_start_d  = 1'b0;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;
        timeout_d    = 1'b0;
        req_d        = '0;
        busy_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_frame_tick) begin
                    state_d = S_CAL;
                    cal_d   = 1'b1;
                end
            end
            S_CAL: begin
                active_d = i_ball_en;
                done_d   = '0;
                wd_d     = '0;
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    state_d = S_REQ;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_REQ: begin
                if (sel_term) begin
                    done_d[idx_q] = 1'b1;
                    wd_d          = '0;
                    state_d       = S_NEXT;
                end else if (sel_ack) begin
                    col_start_d = 1'b1;
                    col_idx_d   = idx_q;
                    wd_d        = '0;
                    state_d     = S_COL;
                end else if (wd_fire) begin
                    timeout_d     = 1'b1;
                    done_d[idx_q] = 1'b1;
                    wd_d          = '0;
                    state_d       = S_NEXT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_COL: begin
                if (i_col_done) begin
                    wd_d    = '0;
                    state_d = S_REQ;
                end else if (wd_fire) begin
                    timeout_d     = 1'b1;
                    done_d[idx_q] = 1'b1;
                    wd_d          = '0;
                    state_d       = S_NEXT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_NEXT: begin
                wd_d = '0;
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    state_d = S_REQ;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A tick that cannot start a frame is dropped and flagged.
        if (i_frame_tick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        if (i_game_start) begin
            state_d      = S_IDLE;
            idx_d        = '0;
            done_d       = '0;
            wd_d         = '0;
            cal_d        = 1'b0;
            col_start_d  = 1'b0;
            frame_done_d = 1'b0;
            overrun_d    = 1'b0;
            timeout_d    = 1'b0;
        end

        if (state_d == S_REQ) begin
            req_d[idx_d] = 1'b1;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            active_q     <= '0;
            done_q       <= '0;
            wd_q         <= '0;
            req_q        <= '0;
            cal_q        <= 1'b0;
            col_start_q  <= 1'b0;
            col_idx_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            done_q       <= done_d;
            wd_q         <= wd_d;
            req_q        <= req_d;
            cal_q        <= cal_d;
            col_start_q  <= col_start_d;
            col_idx_q    <= col_idx_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_cal_frame  = cal_q;
    assign o_ball_req   = req_q;
    assign o_col_start  = col_start_q;
    assign o_col_idx    = col_idx_q;
    assign o_frame_done = frame_done_q;
    assign o_busy       = busy_q;
    assign o_overrun    = overrun_q;
    assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_ball_frame_sched.sv
// tb/tb_ball_frame_sched.sv - randomized self-checking bench for ball_frame_sched
module tb_ball_frame_sched;

    localparam int N  = 3;
    localparam int TO = 15;
    localparam int IW = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         frame_tick;
    logic         game_start;
    logic [N-1:0] ball_en;
    logic [N-1:0] ball_ack;
    logic [N-1:0] ball_term;
    logic         cal_frame;
    logic [N-1:0] ball_req;
    logic         col_start;
    logic [IW-1:0] col_idx;
    logic         col_done;
    logic         frame_done;
    logic         busy;
    logic         overrun;
    logic         timeout_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    ball_frame_sched #(
        .N_BALL  (N),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_frame_tick (frame_tick),
        .i_game_start (game_start),
        .i_ball_en    (ball_en),
        .o_cal_frame  (cal_frame),
        .o_ball_req   (ball_req),
        .i_ball_ack   (ball_ack),
        .i_ball_term  (ball_term),
        .o_col_start  (col_start),
        .o_col_idx    (col_idx),
        .i_col_done   (col_done),
        .o_frame_done (frame_done),
        .o_busy       (busy),
        .o_overrun    (overrun),
        .o_timeout    (timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One frame: ball models answer reactively, the reference predicts the
    // collision-index sequence and timeout count from the enable/silent setup.
    task automatic run_frame(input logic [N-1:0] en, input logic [N-1:0] silent,
                             input bit do_ovr, input bit do_abort);
        int acks[N];
        int dly[N];
        bit answered[N];
        int rise_cyc[N];
        int exp_col[$];
        int exp_to = 0;
        int t0;
        int ack_cyc = -10, done_cyc = -10, ovr_cyc = -10;
        int n_fd = 0, n_to = 0, n_cal = 0, n_ovr = 0;
        int col_cnt = 0, last_col = 0, last_rise = 0;
        bit col_busy = 0, want_rereq = 0, first_req = 1, fin = 0, aborted = 0, ovr_done = 0;
        logic [N-1:0] prev_req = '0;
        logic [N-1:0] low = '0;

        for (int i = N - 1; i >= 0; i--) begin
            if (en[i]) low = N'(1 << i);
        end
        for (int i = 0; i < N; i++) begin
            acks[i] = $urandom_range(0, 3);
            dly[i] = 0;
            answered[i] = 0;
            rise_cyc[i] = 0;
            if (en[i]) begin
                if (silent[i]) exp_to++;
                else for (int k = 0; k < acks[i]; k++) exp_col.push_back(i);
            end
        end

        ball_en = en;
        t0 = cyc;
        frame_tick = 1'b1;
        step();

        for (int c = 0; c < 800 && !fin; c++) begin
            ball_ack = '0;
            ball_term = '0;
            col_done = 1'b0;
            frame_tick = 1'b0;
            game_start = 1'b0;

            if (cal_frame) begin
                n_cal++;
                check("cal_t1", cyc, t0 + 1);
            end
            check("req_legal", 32'($onehot0(ball_req) && ((ball_req & ~en) == '0)), 1);
            if (ball_req != '0 && first_req) begin
                first_req = 0;
                check("req_t2", cyc, t0 + 2);
                check("req_first_lowest", 32'(ball_req), 32'(low));
                ball_en = N'($urandom);
            end
            if (want_rereq && cyc == done_cyc + 1) begin
                want_rereq = 0;
                check("rereq_after_done", 32'(ball_req), 32'(1 << last_col));
            end
            if (col_start) begin
                check("col_start_lat", cyc, ack_cyc + 1);
                if (exp_col.size() == 0) begin
                    check("col_idx_extra", 32'(col_idx), 99);
                end else begin
                    last_col = exp_col.pop_front();
                    check("col_idx", 32'(col_idx), last_col);
                end
                col_busy = 1;
                col_cnt = $urandom_range(0, 3);
            end
            if (timeout_o) begin
                n_to++;
                check("timeout_lat", cyc - rise_cyc[last_rise], TO);
                check("timeout_silent", 32'(silent[last_rise]), 1);
            end
            if (overrun) n_ovr++;
            if (do_ovr && cyc == ovr_cyc + 1) check("overrun_pulse", 32'(overrun), 1);
            if (frame_done) begin
                n_fd++;
                fin = 1;
                check("busy_at_done", 32'(busy), 0);
                if (en == '0) check("frame_done_t3", cyc, t0 + 3);
            end

            for (int i = 0; i < N; i++) begin
                if (ball_req[i] && !prev_req[i]) begin
                    rise_cyc[i] = cyc;
                    last_rise = i;
                    dly[i] = $urandom_range(0, 2);
                    answered[i] = 0;
                end
                if (ball_req[i] && !answered[i] && !silent[i]) begin
                    if (dly[i] == 0) begin
                        answered[i] = 1;
                        if (acks[i] > 0) begin
                            acks[i]--;
                            ball_ack[i] = 1'b1;
                            ack_cyc = cyc;
                        end else begin
                            ball_term[i] = 1'b1;
                            ball_ack[i] = 1'($urandom_range(0, 1));
                        end
                    end else begin
                        dly[i]--;
                    end
                end else if (!ball_req[i]) begin
                    ball_ack[i]  = ($urandom_range(0, 9) == 0);
                    ball_term[i] = ($urandom_range(0, 9) == 0);
                end
            end
            prev_req = ball_req;

            if (col_busy) begin
                if (do_abort) begin
                    game_start = 1'b1;
                    aborted = 1;
                    fin = 1;
                end else if (col_cnt == 0) begin
                    col_done = 1'b1;
                    col_busy = 0;
                    done_cyc = cyc;
                    want_rereq = 1;
                end else begin
                    col_cnt--;
                end
            end

            if (do_ovr && !ovr_done && ball_req != '0 && !game_start) begin
                frame_tick = 1'b1;
                ovr_cyc = cyc;
                ovr_done = 1;
            end
            step();
        end

        ball_ack = '0;
        ball_term = '0;
        col_done = 1'b0;
        frame_tick = 1'b0;
        game_start = 1'b0;

        if (aborted) begin
            check("abort_busy", 32'(busy), 0);
            check("abort_req", 32'(ball_req), 0);
            for (int k = 0; k < 12; k++) begin
                check("abort_no_frame_done", 32'(frame_done), 0);
                step();
            end
        end else begin
            check("frame_finished", 32'(fin), 1);
            check("frame_done_count", n_fd, 1);
            check("cal_count", n_cal, 1);
            check("timeout_count", n_to, exp_to);
            check("col_left", exp_col.size(), 0);
            check("overrun_count", n_ovr, 32'(do_ovr && ovr_done));
            for (int k = 0; k < 3; k++) begin
                check("idle_after_frame", 32'({frame_done, busy, ball_req}), 0);
                step();
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        frame_tick = 1'b0;
        game_start = 1'b0;
        ball_en = '0;
        ball_ack = '0;
        ball_term = '0;
        col_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cal", 32'(cal_frame), 0);
        check("rst_req", 32'(ball_req), 0);
        check("rst_col_start", 32'(col_start), 0);
        check("rst_col_idx", 32'(col_idx), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_timeout", 32'(timeout_o), 0);
        rst_n = 1'b1;
        step();

        run_frame(3'b111, 3'b000, 0, 0);
        run_frame(3'b101, 3'b000, 0, 0);
        run_frame(3'b000, 3'b000, 0, 0);
        run_frame(3'b111, 3'b010, 0, 0);
        run_frame(3'b111, 3'b000, 1, 0);
        run_frame(3'b111, 3'b000, 0, 1);
        run_frame(3'b111, 3'b000, 0, 0);
        for (int r = 0; r < 30; r++) begin
            run_frame(N'($urandom), N'($urandom_range(0, 7) & $urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), (r % 7) == 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
